// File: rtl/disp_digit_buffer.sv
// Eight-slot hex digit buffer for a multiplexed display: registered reads with
// a rotating window offset, a write port, and a sequenced clear.
module disp_digit_buffer #(
  parameter int unsigned STEP_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_blank,
  input  logic       clr,
  input  logic       scroll_en,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_data,
  output logic       rd_blank,
  output logic       busy
);

  localparam int unsigned SW = $clog2(STEP_DIV);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [2:0]      clr_cnt_q, clr_cnt_d;
  logic [7:0][3:0] code_q, code_d;
  logic [7:0]      blank_q, blank_d;
  logic [2:0]      offset_q, offset_d;
  logic [SW-1:0]   step_q, step_d;
  logic [3:0]      rd_data_q, rd_data_d;
  logic            rd_blank_q, rd_blank_d;
  logic [2:0]      rd_idx;

  assign wr_ready = (state_q == IDLE) && !clr;
  assign busy     = (state_q == CLEAR);
  assign rd_data  = rd_data_q;
  assign rd_blank = rd_blank_q;
  assign rd_idx   = rd_addr + offset_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    code_d    = code_q;
    blank_d   = blank_q;
    offset_d  = offset_q;
    step_d    = step_q;
    // Reads sample the pre-edge slot contents, giving read-before-write.
    rd_data_d  = code_q[rd_idx];
    rd_blank_d = blank_q[rd_idx];

    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_cnt_d = 3'd0;
          offset_d  = 3'd0;
          step_d    = '0;
        end else begin
          if (wr_valid && wr_ready) begin
            code_d[wr_addr]  = wr_data;
            blank_d[wr_addr] = wr_blank;
          end
          if (scroll_en) begin
            if (step_q == STEP_LAST) begin
              step_d   = '0;
              offset_d = offset_q + 3'd1;
            end else begin
              step_d = step_q + 1'b1;
            end
          end else begin
            step_d = '0;
          end
        end
      end
      CLEAR: begin
        code_d[clr_cnt_q]  = 4'd0;
        blank_d[clr_cnt_q] = 1'b1;
        clr_cnt_d          = clr_cnt_q + 3'd1;
        step_d             = '0;
        if (clr_cnt_q == 3'd7) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= 3'd0;
      code_q     <= '0;
      blank_q    <= '1;
      offset_q   <= 3'd0;
      step_q     <= '0;
      rd_data_q  <= 4'd0;
      rd_blank_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      code_q     <= code_d;
      blank_q    <= blank_d;
      offset_q   <= offset_d;
      step_q     <= step_d;
      rd_data_q  <= rd_data_d;
      rd_blank_q <= rd_blank_d;
    end
  end

endmodule

// File: doc/disp_digit_buffer.md
DISP_DIGIT_BUFFER -- requirements
Module: disp_digit_buffer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 50_000_000, meaning clk cycles per scroll step (legal range 2..2^26).
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_valid, input, 1, write request.
REQ-005 SHALL have port wr_ready, output, 1, buffer can accept a write this cycle.
REQ-006 SHALL have port wr_addr, input, 3, physical digit slot to write.
REQ-007 SHALL have port wr_data, input, 4, hex code to store.
REQ-008 SHALL have port wr_blank, input, 1, store slot as blanked.
REQ-009 SHALL have port clr, input, 1, single-cycle pulse; starts the clear sequence.
REQ-010 SHALL have port scroll_en, input, 1, level; enables rotation of the displayed window.
REQ-011 SHALL have port rd_addr, input, 3, digit index from the scan counter.
REQ-012 SHALL have port rd_data, output, 4, hex code for rd_addr; feeds the segment pattern stage.
REQ-013 SHALL have port rd_blank, output, 1, digit at rd_addr is blanked.
REQ-014 SHALL have port busy, output, 1, clear sequence in progress.

Function
REQ-015 SHALL hold 8 slots, each 4-bit code plus 1 blank bit.
REQ-016 SHALL implement FSM states IDLE and CLEAR; busy = (state == CLEAR).
REQ-017 SHALL drive wr_ready = (state == IDLE) and not clr, combinationally.
REQ-018 SHALL write slot wr_addr with {wr_data, wr_blank} on a clock edge where wr_valid and wr_ready are both 1; no write otherwise.
REQ-019 SHALL, on clr = 1 in IDLE, enter CLEAR, set offset to 0, and clear the slot counter; a wr_valid in that cycle is not accepted.
REQ-020 SHALL, in CLEAR, write slot[k] = {0000, blank=1} for k = 0..7, one per cycle, then return to IDLE; busy is high for exactly 8 cycles.
REQ-021 SHALL ignore clr while in CLEAR; the sequence is not restarted or extended.
REQ-022 SHALL register reads: rd_data/rd_blank on edge n reflect slot[(rd_addr + offset) mod 8] sampled at edge n, i.e. 1-cycle latency.
REQ-023 SHALL return pre-write contents when read and write target the same slot on the same edge (read-before-write).
REQ-024 SHALL, while scroll_en = 1 and state = IDLE, count clk cycles 0..STEP_DIV-1 and increment offset by 1 on each wrap; offset wraps 7 -> 0.
REQ-025 SHALL, while scroll_en = 0 or in CLEAR, hold the step counter at 0 and hold offset.
REQ-026 SHALL restart the step count from 0 when scroll_en rises, so the first step occurs STEP_DIV cycles later.
REQ-027 SHALL continue servicing reads during CLEAR; the displayed content changes as slots clear.

Reset
REQ-028 SHALL, while rst_n = 0, force state IDLE, all slots {0000, blank=1}, offset 0, step counter 0, rd_data 0000, rd_blank 1, busy 0, independent of clk.
REQ-029 SHALL abort any clear sequence in progress on reset assertion; after release, wr_ready = 1 if clr = 0.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 Write then read: write slot3 = {A, blank=0}, then rd_addr=3 with scroll_en=0 -> one cycle later rd_data=A, rd_blank=0; other slots read 0000/blank 1.
REQ-032 Collision: write slot5 = 7 while rd_addr=5 -> same edge returns old value, next edge returns 7.
REQ-033 Clear vs write: clr=1 and wr_valid=1 same cycle -> wr_ready=0, write dropped, busy high 8 cycles, all slots {0000,1}, offset 0.
REQ-034 Scroll with STEP_DIV=4: slots 0..7 = 0..7, scroll_en=1 -> offset increments every 4 cycles; rd_addr=0 reads 1, 2, ... 7, 0 (wrap).
REQ-035 Reset mid-clear: assert rst_n=0 on the 3rd CLEAR cycle -> busy=0, rd_blank=1 immediately; after release, wr_ready=1 and first write accepted.
REQ-036 Busy back-pressure: hold wr_valid=1 through CLEAR -> no write during the 8 busy cycles, accepted on the first IDLE cycle.
